// File: rtl/uoram_access_scheduler.sv
// Arbitrates program and posmap requests onto the ORAM backend, then sequences the
// switch / command / data-transfer phases and watches the datapath handshakes.
module uoram_access_scheduler #(
  parameter int FEORAMBChunks = 8,
  parameter int ORAMU         = 32,
  parameter int BECMDWidth    = 3,
  parameter int MaxPMStreak   = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ProgValid,
  output logic                  ProgReady,
  input  logic [BECMDWidth-1:0] ProgCmd,
  input  logic [ORAMU-1:0]      ProgAddr,
  input  logic                  ProgDumb,
  input  logic                  PMValid,
  output logic                  PMReady,
  input  logic                  PMIsEvict,
  input  logic [ORAMU-1:0]      PMAddr,
  output logic                  BECmdValid,
  input  logic                  BECmdReady,
  output logic [BECMDWidth-1:0] BECmd,
  output logic [ORAMU-1:0]      BEAddr,
  output logic                  SwitchReq,
  output logic                  DataBlockReq,
  output logic [BECMDWidth-1:0] Cmd,
  output logic                  DumbRequest,
  input  logic                  StoreDataValid,
  input  logic                  StoreDataReady,
  input  logic                  LoadDataValid,
  input  logic                  LoadDataReady,
  output logic                  Busy,
  output logic                  ProtocolErr
);

  localparam logic [BECMDWidth-1:0] BECMD_Update  = BECMDWidth'(0);
  localparam logic [BECMDWidth-1:0] BECMD_Append  = BECMDWidth'(1);
  localparam logic [BECMDWidth-1:0] BECMD_Read    = BECMDWidth'(2);
  localparam logic [BECMDWidth-1:0] BECMD_ReadRmv = BECMDWidth'(3);

  localparam int CntW    = $clog2(FEORAMBChunks + 1);
  localparam int StreakW = $clog2(MaxPMStreak + 1);
  localparam logic [CntW-1:0]    Chunks    = CntW'(FEORAMBChunks);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MaxPMStreak);

  typedef enum logic [1:0] {IDLE, SWITCH, CMD, XFER} state_t;

  state_t                state, nextState;
  logic [BECMDWidth-1:0] cmdReg;
  logic [ORAMU-1:0]      addrReg;
  logic                  dataBlockReg, dumbReg;
  logic                  needStore, needLoad;
  logic [CntW-1:0]       storeCnt, loadCnt, storeNext, loadNext, storeReq, loadReq;
  logic [StreakW-1:0]    streak;
  logic                  protoErr;
  logic                  storeHs, loadHs, countsDone, overCount;
  logic                  streakFull, pmWins, progWins, progIsRead, progIsWrite;

  assign storeHs = StoreDataValid && StoreDataReady;
  assign loadHs  = LoadDataValid && LoadDataReady;

  assign storeReq  = needStore ? Chunks : '0;
  assign loadReq   = needLoad ? Chunks : '0;
  assign storeNext = (storeHs && storeCnt != Chunks) ? storeCnt + CntW'(1) : storeCnt;
  assign loadNext  = (loadHs && loadCnt != Chunks) ? loadCnt + CntW'(1) : loadCnt;
  // Includes this cycle's handshake so XFER exits right after the final beat.
  assign countsDone = (storeNext >= storeReq) && (loadNext >= loadReq);
  assign overCount  = (storeHs && storeCnt >= storeReq) || (loadHs && loadCnt >= loadReq);

  // Posmap has priority, except once it has starved a waiting program request long enough.
  assign streakFull = (streak == StreakMax);
  assign pmWins     = PMValid && !(ProgValid && streakFull);
  assign progWins   = ProgValid && !pmWins;

  assign progIsRead  = (ProgCmd == BECMD_Read) || (ProgCmd == BECMD_ReadRmv);
  assign progIsWrite = (ProgCmd == BECMD_Append) || (ProgCmd == BECMD_Update);

  always_comb begin
    nextState = state;
    ProgReady = 1'b0;
    PMReady   = 1'b0;
    case (state)
      IDLE: begin
        ProgReady = progWins;
        PMReady   = pmWins;
        if (pmWins || progWins) nextState = SWITCH;
      end
      SWITCH: nextState = CMD;
      CMD: begin
        if (BECmdReady) nextState = (needStore || needLoad) ? XFER : IDLE;
      end
      XFER: begin
        if (countsDone) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state        <= IDLE;
      cmdReg       <= '0;
      addrReg      <= '0;
      dataBlockReg <= 1'b0;
      dumbReg      <= 1'b0;
      needStore    <= 1'b0;
      needLoad     <= 1'b0;
      storeCnt     <= '0;
      loadCnt      <= '0;
      streak       <= '0;
      protoErr     <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE) begin
        if (progWins) begin
          cmdReg       <= ProgCmd;
          addrReg      <= ProgAddr;
          dataBlockReg <= 1'b1;
          dumbReg      <= ProgDumb;
          needStore    <= progIsWrite || (progIsRead && ProgDumb);
          needLoad     <= progIsRead;
        end else if (pmWins) begin
          cmdReg       <= PMIsEvict ? BECMD_Append : BECMD_Read;
          addrReg      <= PMAddr;
          dataBlockReg <= 1'b0;
          dumbReg      <= 1'b0;
          needStore    <= PMIsEvict;
          needLoad     <= !PMIsEvict;
        end
        if (progWins || (pmWins && !ProgValid)) streak <= '0;
        else if (pmWins && !streakFull) streak <= streak + StreakW'(1);
      end
      // Counting starts in SWITCH so data arriving ahead of the command is kept.
      if (state == IDLE || nextState == IDLE) begin
        storeCnt <= '0;
        loadCnt  <= '0;
      end else begin
        storeCnt <= storeNext;
        loadCnt  <= loadNext;
      end
      if ((state == IDLE && (storeHs || loadHs)) ||
          (state != IDLE && overCount) ||
          (BECmdReady && state != CMD))
        protoErr <= 1'b1;
    end
  end

  assign SwitchReq    = (state == SWITCH);
  assign BECmdValid   = (state == CMD);
  assign Busy         = (state != IDLE);
  assign BECmd        = cmdReg;
  assign Cmd          = cmdReg;
  assign BEAddr       = addrReg;
  assign DataBlockReq = dataBlockReg;
  assign DumbRequest  = dumbReg;
  assign ProtocolErr  = protoErr;

endmodule

// File: tb/tb_uoram_access_scheduler.sv
// Directed bench: walks the scheduler through program, posmap, dumb-read, reset and
// error scenarios with hand-computed expectations.
module tb_uoram_access_scheduler;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ProgValid, ProgDumb, PMValid, PMIsEvict, BECmdReady;
  logic [2:0]  ProgCmd;
  logic [31:0] ProgAddr, PMAddr;
  logic        StoreDataValid, StoreDataReady, LoadDataValid, LoadDataReady;
  logic        ProgReady, PMReady, BECmdValid, SwitchReq, DataBlockReq, DumbRequest;
  logic        Busy, ProtocolErr;
  logic [2:0]  BECmd, Cmd;
  logic [31:0] BEAddr;

  int checks = 0;
  int failures = 0;

  uoram_access_scheduler dut (
    .Clock(Clock), .Reset(Reset),
    .ProgValid(ProgValid), .ProgReady(ProgReady), .ProgCmd(ProgCmd),
    .ProgAddr(ProgAddr), .ProgDumb(ProgDumb),
    .PMValid(PMValid), .PMReady(PMReady), .PMIsEvict(PMIsEvict), .PMAddr(PMAddr),
    .BECmdValid(BECmdValid), .BECmdReady(BECmdReady), .BECmd(BECmd), .BEAddr(BEAddr),
    .SwitchReq(SwitchReq), .DataBlockReq(DataBlockReq), .Cmd(Cmd),
    .DumbRequest(DumbRequest),
    .StoreDataValid(StoreDataValid), .StoreDataReady(StoreDataReady),
    .LoadDataValid(LoadDataValid), .LoadDataReady(LoadDataReady),
    .Busy(Busy), .ProtocolErr(ProtocolErr)
  );

  always #5 Clock = ~Clock;

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_switch"}, SwitchReq, 0);
    check({tag, "_becmdvalid"}, BECmdValid, 0);
    check({tag, "_cmd"}, Cmd, 0);
    check({tag, "_becmd"}, BECmd, 0);
    check({tag, "_beaddr"}, BEAddr, 0);
    check({tag, "_datablock"}, DataBlockReq, 0);
    check({tag, "_dumb"}, DumbRequest, 0);
    check({tag, "_perr"}, ProtocolErr, 0);
  endtask

  task automatic doReset();
    Reset = 1'b0;
    cyc();
    Reset = 1'b1;
  endtask

  task automatic stores(input int n, input string tag);
    StoreDataValid = 1'b1; StoreDataReady = 1'b1;
    for (int i = 0; i < n; i++) begin
      settle();
      check($sformatf("%s_busy_st%0d", tag, i), Busy, 1);
      cyc();
    end
    StoreDataValid = 1'b0; StoreDataReady = 1'b0;
  endtask

  task automatic loads(input int n, input string tag);
    LoadDataValid = 1'b1; LoadDataReady = 1'b1;
    for (int i = 0; i < n; i++) begin
      settle();
      check($sformatf("%s_busy_ld%0d", tag, i), Busy, 1);
      cyc();
    end
    LoadDataValid = 1'b0; LoadDataReady = 1'b0;
  endtask

  // Expected grant order with both sides valid: 1 = posmap, 0 = program.
  logic expPM [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    Reset = 1'b0;
    ProgValid = 0; ProgDumb = 0; ProgCmd = 0; ProgAddr = 0;
    PMValid = 0; PMIsEvict = 0; PMAddr = 0; BECmdReady = 0;
    StoreDataValid = 0; StoreDataReady = 0; LoadDataValid = 0; LoadDataReady = 0;
    cyc(); cyc();
    settle();
    checkResetOutputs("reset");
    check("reset_progready", ProgReady, 0);
    check("reset_pmready", PMReady, 0);
    Reset = 1'b1;
    cyc();

    // Program Append at 0x10 with BECmdReady held high.
    BECmdReady = 1'b1;
    ProgValid = 1'b1; ProgCmd = 3'd1; ProgAddr = 32'h10;
    settle();
    check("app_progready", ProgReady, 1);
    check("app_pmready", PMReady, 0);
    cyc();
    ProgValid = 1'b0;
    settle();
    check("app_switch", SwitchReq, 1);
    check("app_becmdvalid_early", BECmdValid, 0);
    check("app_datablock", DataBlockReq, 1);
    check("app_cmd", Cmd, 1);
    cyc();
    settle();
    check("app_becmdvalid", BECmdValid, 1);
    check("app_beaddr", BEAddr, 32'h10);
    check("app_becmd", BECmd, 1);
    check("app_switch_off", SwitchReq, 0);
    cyc();
    stores(8, "app");
    settle();
    check("app_busy_done", Busy, 0);
    check("app_perr_ready_idle", ProtocolErr, 1);
    BECmdReady = 1'b0;
    doReset();
    settle();
    check("app_perr_cleared", ProtocolErr, 0);

    // Both sides continuously valid: posmap streak limited to four.
    ProgValid = 1'b1; ProgCmd = 3'd1; ProgAddr = 32'h20;
    PMValid = 1'b1; PMIsEvict = 1'b1; PMAddr = 32'h30;
    for (int k = 0; k < 6; k++) begin
      settle();
      check($sformatf("arb%0d_pmready", k), PMReady, expPM[k]);
      check($sformatf("arb%0d_progready", k), ProgReady, !expPM[k]);
      $display("arb grant %0d: pm=%0b prog=%0b", k, PMReady, ProgReady);
      cyc();
      settle();
      check($sformatf("arb%0d_datablock", k), DataBlockReq, !expPM[k]);
      check($sformatf("arb%0d_beaddr", k), BEAddr, expPM[k] ? 32'h30 : 32'h20);
      cyc();
      BECmdReady = 1'b1;
      settle();
      check($sformatf("arb%0d_becmdvalid", k), BECmdValid, 1);
      cyc();
      BECmdReady = 1'b0;
      stores(8, $sformatf("arb%0d", k));
      settle();
      check($sformatf("arb%0d_idle", k), Busy, 0);
    end
    ProgValid = 1'b0; PMValid = 1'b0;
    settle();
    check("arb_perr", ProtocolErr, 0);
    doReset();

    // Dumb read: loads complete first, must still wait for stores.
    ProgValid = 1'b1; ProgCmd = 3'd2; ProgDumb = 1'b1; ProgAddr = 32'h40;
    settle();
    check("dumb_progready", ProgReady, 1);
    cyc();
    ProgValid = 1'b0; ProgDumb = 1'b0;
    settle();
    check("dumb_dumbreq", DumbRequest, 1);
    check("dumb_cmd", Cmd, 2);
    cyc();
    BECmdReady = 1'b1;
    cyc();
    BECmdReady = 1'b0;
    loads(8, "dumb");
    settle();
    check("dumb_busy_after_loads", Busy, 1);
    cyc();
    settle();
    check("dumb_busy_hold", Busy, 1);
    stores(8, "dumb");
    settle();
    check("dumb_idle", Busy, 0);
    check("dumb_perr", ProtocolErr, 0);

    // Posmap refill interrupted by reset after three loads.
    PMValid = 1'b1; PMIsEvict = 1'b0; PMAddr = 32'h55;
    settle();
    check("refill_pmready", PMReady, 1);
    cyc();
    PMValid = 1'b0;
    settle();
    check("refill_cmd", Cmd, 2);
    check("refill_datablock", DataBlockReq, 0);
    cyc();
    BECmdReady = 1'b1;
    cyc();
    BECmdReady = 1'b0;
    loads(3, "refill");
    doReset();
    settle();
    checkResetOutputs("midreset");

    // Non-data command returns to IDLE straight from CMD.
    ProgValid = 1'b1; ProgCmd = 3'd7; ProgAddr = 32'h77;
    settle();
    check("nodata_progready", ProgReady, 1);
    cyc();
    ProgValid = 1'b0;
    settle();
    check("nodata_switch", SwitchReq, 1);
    cyc();
    settle();
    check("nodata_becmdvalid", BECmdValid, 1);
    check("nodata_beaddr", BEAddr, 32'h77);
    check("nodata_becmd", BECmd, 7);
    BECmdReady = 1'b1;
    cyc();
    BECmdReady = 1'b0;
    settle();
    check("nodata_idle", Busy, 0);
    check("nodata_perr", ProtocolErr, 0);

    // Store handshake while idle is a sticky protocol error.
    StoreDataValid = 1'b1; StoreDataReady = 1'b1;
    cyc();
    StoreDataValid = 1'b0; StoreDataReady = 1'b0;
    settle();
    check("idle_store_perr", ProtocolErr, 1);
    cyc(); cyc(); cyc();
    settle();
    check("idle_store_perr_sticky", ProtocolErr, 1);
    check("idle_store_busy", Busy, 0);
    doReset();
    settle();
    check("idle_store_perr_reset", ProtocolErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uoram_access_scheduler.md
UORAM_ACCESS_SCHEDULER -- requirements
Module: uoram_access_scheduler

Interface
REQ-001 Parameter: FEORAMBChunks, default 8, front-end data chunks per ORAM block.
REQ-002 Parameter: ORAMU, default 32, block address width.
REQ-003 Parameter: BECMDWidth, default 3, backend command width; encodings BECMD_Read, BECMD_ReadRmv, BECMD_Append, BECMD_Update come from the shared command header.
REQ-004 Parameter: MaxPMStreak, default 4, maximum consecutive posmap grants while a program request waits.
REQ-005 Port: Clock  in  1  single clock; all logic on its rising edge.
REQ-006 Port: Reset  in  1  synchronous, active-low (0 = reset).
REQ-007 Ports: ProgValid in 1, ProgReady out 1, ProgCmd in BECMDWidth, ProgAddr in ORAMU, ProgDumb in 1.
- Program request channel.
- ProgDumb marks a read of a non-existent block.
REQ-008 Ports: PMValid in 1, PMReady out 1, PMIsEvict in 1, PMAddr in ORAMU.
- Posmap (PLB) request channel.
- PMIsEvict: 1 = evict, 0 = refill.
REQ-009 Ports: BECmdValid out 1, BECmdReady in 1, BECmd out BECMDWidth, BEAddr out ORAMU.
- Backend command channel.
REQ-010 Ports: SwitchReq out 1, DataBlockReq out 1, Cmd out BECMDWidth, DumbRequest out 1.
- Datapath control outputs.
REQ-011 Ports: StoreDataValid, StoreDataReady, LoadDataValid, LoadDataReady, all in 1.
- Monitored datapath/backend handshakes.
REQ-012 Ports: Busy out 1, ProtocolErr out 1 (sticky).

Function
REQ-013 FSM states:
- IDLE: accepts requests.
- SWITCH: SwitchReq=1 for exactly one cycle.
- CMD: BECmdValid=1 until BECmdReady.
- XFER: counts data handshakes.
REQ-014 IDLE arbitration (combinational; ready asserted only to the winner, and only if that side is valid):
- Posmap wins when both are valid, unless Streak==MaxPMStreak, in which case Program wins.
REQ-015 A grant captures the request on the ProgValid&&ProgReady or PMValid&&PMReady cycle; next state is SWITCH; exactly one grant per request.
REQ-016 Captured fields held stable from capture cycle+1 until the return to IDLE.
- Program grant: DataBlockReq=1, Cmd=ProgCmd, DumbRequest=ProgDumb.
- Posmap grant: DataBlockReq=0, Cmd=BECMD_Append if evict else BECMD_Read, DumbRequest=0.
REQ-017 BECmd=Cmd and BEAddr=captured address while in CMD; latency from grant to BECmdValid = 2 cycles; CMD->XFER on the BECmdReady cycle.
REQ-018 XFER required counts:
- Read/ReadRmv non-dumb: FEORAMBChunks loads.
- Read/ReadRmv dumb: FEORAMBChunks stores AND FEORAMBChunks loads.
- Append/Update, and posmap evict: FEORAMBChunks stores.
- Posmap refill: FEORAMBChunks loads.
- Any other Cmd: zero; CMD goes directly to IDLE on BECmdReady.
REQ-019 Store count increments on StoreDataValid&&StoreDataReady; load count increments on LoadDataValid&&LoadDataReady; width ceil(log2(FEORAMBChunks+1)); saturate at FEORAMBChunks.
- Handshakes are counted in SWITCH, CMD and XFER, so early data is not lost.
REQ-020 XFER->IDLE in the cycle after both required counts are reached; counters clear on IDLE entry; a new grant is possible in the first IDLE cycle.
REQ-021 Streak:
- Increments (saturating at MaxPMStreak) on a posmap grant while ProgValid=1.
- Clears on a program grant, or on any grant while ProgValid=0.
REQ-022 Busy=1 in every state except IDLE.
REQ-023 ProtocolErr set and held when any of these occur; cleared only by reset:
- a store or load handshake while in IDLE;
- a count exceeding its requirement;
- BECmdReady while not in CMD.

Reset
REQ-024 When Reset=0 at a clock edge, the FSM returns to IDLE from any state, including mid-XFER, and the in-flight request is dropped.
REQ-025 Reset values: counters 0, Streak 0, ProtocolErr 0, Busy 0.
REQ-026 Reset values: SwitchReq, BECmdValid, ProgReady, PMReady, DataBlockReq, DumbRequest all 0; Cmd and BECmd = 0; BEAddr = 0.

Verification
REQ-027 Program Append at addr 0x10, BECmdReady held 1, 8 stores:
- SwitchReq at grant+1; BECmdValid at grant+2 with BEAddr=0x10;
- Busy drops the cycle after the 8th store.
REQ-028 ProgValid and PMValid held high continuously, MaxPMStreak=4:
- grant order PM,PM,PM,PM,Prog,PM,...;
- DataBlockReq=0 during PM accesses and 1 during the Prog access.
REQ-029 Dumb Read, 8 loads then 8 stores:
- stays in XFER after the 8 loads;
- returns to IDLE only after the 8th store; ProtocolErr=0.
REQ-030 Posmap refill with 3 of 8 loads done, Reset=0 for one cycle:
- next cycle IDLE with all outputs at reset values;
- a new request is granted normally afterwards.
REQ-031 Store handshake injected while IDLE -> ProtocolErr=1 and stays 1 until Reset=0.
REQ-032 Program command with non-data encoding -> IDLE on the BECmdReady cycle, no XFER state.
